// File: rtl/add_and_sub_pkg.sv
// Shared constants for the registered adder/subtractor.
package add_and_sub_pkg;
  localparam int unsigned ADDSUB_WIDTH = 6;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/add_and_sub_rca.sv
// Purely combinational WIDTH-bit ripple-carry adder built from full-adder cells.
module add_and_sub_rca
  import add_and_sub_pkg::*;
#(
  parameter int unsigned WIDTH = ADDSUB_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  logic [WIDTH:0] carry;

  assign carry[0] = carry_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = x[i] ^ y[i] ^ carry[i];
    assign carry[i+1] = (x[i] & y[i]) | (x[i] & carry[i]) | (y[i] & carry[i]);
  end

  assign carry_out = carry[WIDTH];
endmodule

// File: rtl/add_and_sub.sv
// Registered two's-complement adder/subtractor, one-cycle latency.
// Optional status flags (carry_out, overflow, zero) enabled by ADDSUB_STATUS_EN.
module add_and_sub
  import add_and_sub_pkg::*;
#(
  parameter int unsigned WIDTH = ADDSUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub_sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] result
`ifdef ADDSUB_STATUS_EN
  ,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
`endif
);
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             sum_carry;

  // Subtract as a + ~b + 1 so one adder serves both operations.
  assign b_eff = b ^ {WIDTH{sub_sel}};

  add_and_sub_rca #(.WIDTH(WIDTH)) u_rca (
    .x         (a),
    .y         (b_eff),
    .carry_in  (sub_sel),
    .sum       (sum),
    .carry_out (sum_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) result <= sum;
    end
  end

`ifdef ADDSUB_STATUS_EN
  logic carry_next;
  logic overflow_next;

  // Carry on add, borrow (inverted carry) on subtract.
  assign carry_next    = (sub_sel == OP_SUB) ? ~sum_carry : sum_carry;
  assign overflow_next = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (in_valid) begin
      carry_out <= carry_next;
      overflow  <= overflow_next;
      zero      <= (sum == '0);
    end
  end
`endif
endmodule

// File: tb/tb_add_and_sub.sv
// Self-checking bench for add_and_sub: directed cases plus random stimulus
// against an arithmetic reference model.
module tb_add_and_sub;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub_sel = 1'b0;
  logic         out_valid;
  logic [W-1:0] result;
`ifdef ADDSUB_STATUS_EN
  logic         carry_out;
  logic         overflow;
  logic         zero;
`endif

  add_and_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sub_sel   (sub_sel),
    .out_valid (out_valid),
    .result    (result)
`ifdef ADDSUB_STATUS_EN
    ,
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: what the outputs should be after the latest edge.
  logic         m_valid = 1'b0;
  logic [W-1:0] m_result = '0;
  logic         m_carry = 1'b0;
  logic         m_ovf = 1'b0;
  logic         m_zero = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step(input string tag, input logic r, input logic v,
                      input logic [W-1:0] ia, input logic [W-1:0] ib, input logic s);
    int ua, ub, sa, sb, full, sres;
    @(negedge clk);
    rst = r; in_valid = v; a = ia; b = ib; sub_sel = s;
    @(posedge clk);
    ua = int'(ia); ub = int'(ib);
    sa = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
    if (r) begin
      m_valid = 1'b0; m_result = '0; m_carry = 1'b0; m_ovf = 1'b0; m_zero = 1'b0;
    end else begin
      m_valid = v;
      if (v) begin
        full     = s ? ua - ub : ua + ub;
        m_result = W'(full);
        m_carry  = s ? (ua < ub) : (full > (1 << W) - 1);
        sres     = s ? sa - sb : sa + sb;
        m_ovf    = (sres > (1 << (W-1)) - 1) || (sres < -(1 << (W-1)));
        m_zero   = (m_result == '0);
      end
    end
    #1;
    check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".result"}, 32'(result), 32'(m_result));
`ifdef ADDSUB_STATUS_EN
    check({tag, ".carry"}, 32'(carry_out), 32'(m_carry));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".zero"}, 32'(zero), 32'(m_zero));
`endif
  endtask

  logic [W-1:0] add_a [5] = '{6'h02, 6'h04, 6'h05, 6'h06, 6'h0D};
  logic [W-1:0] add_b [5] = '{6'h03, 6'h07, 6'h0A, 6'h0E, 6'h09};
  logic [W-1:0] add_r [5] = '{6'h05, 6'h0B, 6'h0F, 6'h14, 6'h16};
  logic [W-1:0] sub_a [6] = '{6'h06, 6'h04, 6'h0A, 6'h06, 6'h0D, 6'h00};
  logic [W-1:0] sub_b [6] = '{6'h03, 6'h07, 6'h05, 6'h0F, 6'h09, 6'h0E};
  logic [W-1:0] sub_r [6] = '{6'h03, 6'h3D, 6'h05, 6'h37, 6'h04, 6'h32};

  initial begin
    // Reset held with a live operand: outputs must stay cleared.
    for (int i = 0; i < 2; i++) step("reset", 1'b1, 1'b1, 6'h05, 6'h03, 1'b0);

    for (int i = 0; i < 5; i++) begin
      step("add", 1'b0, 1'b1, add_a[i], add_b[i], 1'b0);
      check("add.table", 32'(result), 32'(add_r[i]));
    end
    for (int i = 0; i < 6; i++) begin
      step("sub", 1'b0, 1'b1, sub_a[i], sub_b[i], 1'b1);
      check("sub.table", 32'(result), 32'(sub_r[i]));
    end

    step("wrap", 1'b0, 1'b1, 6'h3F, 6'h01, 1'b0);
    check("wrap.const", 32'(result), 32'h00);
    for (int i = 0; i < 3; i++) begin
      step("gap", 1'b0, 1'b0, 6'h2A, 6'h15, 1'b1);
      check("gap.hold", 32'(result), 32'h00);
    end
    step("sub20", 1'b0, 1'b1, 6'h20, 6'h01, 1'b1);
    check("sub20.const", 32'(result), 32'h1F);

    // Mid-stream reset, then reset coinciding with a valid operand.
    step("mid_op", 1'b0, 1'b1, 6'h10, 6'h10, 1'b0);
    step("mid_rst", 1'b1, 1'b1, 6'h10, 6'h10, 1'b0);
    check("mid_rst.const", 32'(result), 32'h00);
    step("resume", 1'b0, 1'b1, 6'h01, 6'h02, 1'b0);
    check("resume.const", 32'(result), 32'h03);

    step("st_wrap", 1'b0, 1'b1, 6'h3F, 6'h01, 1'b0);
    step("st_ovf", 1'b0, 1'b1, 6'h1F, 6'h01, 1'b0);
    step("st_borrow", 1'b0, 1'b1, 6'h04, 6'h07, 1'b1);
    step("st_zero", 1'b0, 1'b1, 6'h0D, 6'h0D, 1'b1);
`ifdef ADDSUB_STATUS_EN
    check("st_zero.zero_const", 32'(zero), 32'h1);
`endif

    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
           W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
